// File: rtl/if_stage_pkg.sv
// if_stage_pkg
// Shared constants and types for the instruction-fetch stage.
//   - Reset / handler vectors and the bubble instruction word
//   - IRQ request FSM state encoding
//   - pc_inc(): PC+4 that keeps bit 31 (kernel mode) and wraps the low 31 bits
package if_stage_pkg;

    localparam logic [31:0] RESET_PC   = 32'h8000_0000;
    localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;
    localparam logic [31:0] EXC_VECTOR = 32'h8000_0008;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    typedef enum logic {
        IRQ_IDLE    = 1'b0,
        IRQ_PENDING = 1'b1
    } irq_state_t;

    // Kernel/user bit is sticky across sequential fetch; only the
    // low 31 bits count and they wrap at 2^31.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/if_stage_irq_request.sv
// if_stage_irq_request
// Turns the synchronous irq level into a single pending request and decides
// when the fetch stage may take it.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_irq            external interrupt level
//   i_hold           hazard stall (fetch stage frozen this cycle)
//   i_exception      exception wins over the interrupt this cycle
//   i_redirect       redirect in flight; interrupt deferred one cycle
//   i_kernel         PC[31]; interrupts are masked in kernel mode
//   o_irq_take       accept the interrupt this cycle
//
// state       | meaning
// ------------+------------------------------------------------------
// IRQ_IDLE    | no request outstanding; waiting for an irq rising edge
// IRQ_PENDING | request latched; taken on the first qualifying cycle
module if_stage_irq_request
    import if_stage_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_irq,
    input  logic i_hold,
    input  logic i_exception,
    input  logic i_redirect,
    input  logic i_kernel,
    output logic o_irq_take
);

    irq_state_t r_state;
    irq_state_t w_state_next;
    logic       r_irq_prev;
    logic       w_irq_rise;

    assign w_irq_rise = i_irq & ~r_irq_prev;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IRQ_IDLE;
            r_irq_prev <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_irq_prev <= i_irq;
        end
    end

    // A rising edge seen while already pending is simply absorbed.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IRQ_IDLE:    if (w_irq_rise) w_state_next = IRQ_PENDING;
            IRQ_PENDING: if (o_irq_take) w_state_next = IRQ_IDLE;
            default:     w_state_next = IRQ_IDLE;
        endcase
    end

    always_comb begin
        o_irq_take = (r_state == IRQ_PENDING) & ~i_kernel & ~i_redirect
                   & ~i_hold & ~i_exception;
    end

endmodule

// File: rtl/if_stage.sv
// if_stage
// Instruction-fetch stage: PC register, next-PC selection and IF/ID register.
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_id_ex_clear             stall: hold PC and IF/ID
//   i_if_id_clear             flush: load a bubble into IF/ID
//   i_redirect/_target        taken branch / jump from ID
//   i_exception               ID holds an undefined instruction
//   i_irq                     external interrupt level
//   i_imem_rdata              instruction at o_imem_addr (combinational ROM)
//   o_imem_addr               current PC
//   o_if_id_instr/_pc_plus4/_valid   IF/ID register
//   o_epc, o_epc_we, o_cause_irq     handler return address write
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] P_RESET_PC   = RESET_PC,
    parameter logic [31:0] P_IRQ_VECTOR = IRQ_VECTOR,
    parameter logic [31:0] P_EXC_VECTOR = EXC_VECTOR,
    parameter logic [31:0] P_NOP_INSTR  = NOP_INSTR
)
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_id_ex_clear,
    input  logic        i_if_id_clear,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_target,
    input  logic        i_exception,
    input  logic        i_irq,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_if_id_instr,
    output logic [31:0] o_if_id_pc_plus4,
    output logic        o_if_id_valid,
    output logic [31:0] o_epc,
    output logic        o_epc_we,
    output logic        o_cause_irq
);

    logic [31:0] r_pc;
    logic [31:0] r_if_id_instr;
    logic [31:0] r_if_id_pc_plus4;
    logic        r_if_id_valid;
    logic [31:0] r_epc;
    logic        r_epc_we;
    logic        r_cause_irq;
    logic [31:0] w_pc_plus4;
    logic        w_irq_take;

    assign w_pc_plus4 = pc_inc(r_pc);

    if_stage_irq_request u_irq_request (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_irq       (i_irq),
        .i_hold      (i_id_ex_clear),
        .i_exception (i_exception),
        .i_redirect  (i_redirect),
        .i_kernel    (r_pc[31]),
        .o_irq_take  (w_irq_take)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc             <= P_RESET_PC;
            r_if_id_instr    <= P_NOP_INSTR;
            r_if_id_pc_plus4 <= 32'd0;
            r_if_id_valid    <= 1'b0;
            r_epc            <= 32'd0;
            r_epc_we         <= 1'b0;
            r_cause_irq      <= 1'b0;
        end else begin
            r_epc_we <= 1'b0;
            if (i_id_ex_clear) begin
                // Hold everything; a pending irq simply waits.
            end else if (i_exception) begin
                r_pc             <= P_EXC_VECTOR;
                r_if_id_instr    <= P_NOP_INSTR;
                r_if_id_pc_plus4 <= 32'd0;
                r_if_id_valid    <= 1'b0;
                r_epc            <= r_if_id_pc_plus4 - 32'd4;
                r_epc_we         <= 1'b1;
                r_cause_irq      <= 1'b0;
            end else if (w_irq_take) begin
                // The fetch at r_pc is discarded and resumed after the handler.
                r_pc             <= P_IRQ_VECTOR;
                r_if_id_instr    <= P_NOP_INSTR;
                r_if_id_pc_plus4 <= 32'd0;
                r_if_id_valid    <= 1'b0;
                r_epc            <= r_pc;
                r_epc_we         <= 1'b1;
                r_cause_irq      <= 1'b1;
            end else begin
                r_pc <= i_redirect ? i_redirect_target : w_pc_plus4;
                if (i_if_id_clear) begin
                    r_if_id_instr    <= P_NOP_INSTR;
                    r_if_id_pc_plus4 <= 32'd0;
                    r_if_id_valid    <= 1'b0;
                end else begin
                    r_if_id_instr    <= i_imem_rdata;
                    r_if_id_pc_plus4 <= w_pc_plus4;
                    r_if_id_valid    <= 1'b1;
                end
            end
        end
    end

    assign o_imem_addr      = r_pc;
    assign o_if_id_instr    = r_if_id_instr;
    assign o_if_id_pc_plus4 = r_if_id_pc_plus4;
    assign o_if_id_valid    = r_if_id_valid;
    assign o_epc            = r_epc;
    assign o_epc_we         = r_epc_we;
    assign o_cause_irq      = r_cause_irq;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        id_ex_clear;
    logic        if_id_clear;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        exception;
    logic        irq;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [31:0] epc;
    logic        epc_we;
    logic        cause_irq;

    int n_checks;
    int n_errors;

    if_stage dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .i_id_ex_clear     (id_ex_clear),
        .i_if_id_clear     (if_id_clear),
        .i_redirect        (redirect),
        .i_redirect_target (redirect_target),
        .i_exception       (exception),
        .i_irq             (irq),
        .i_imem_rdata      (imem_rdata),
        .o_imem_addr       (imem_addr),
        .o_if_id_instr     (if_id_instr),
        .o_if_id_pc_plus4  (if_id_pc_plus4),
        .o_if_id_valid     (if_id_valid),
        .o_epc             (epc),
        .o_epc_we          (epc_we),
        .o_cause_irq       (cause_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        redir;
        logic [31:0] tgt;
        logic        exc;
        logic        irq;
        logic [31:0] rdata;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pp4;
        logic        e_we;
        logic [31:0] e_epc;
        logic        e_cause;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, input logic stall, input logic flush, input logic redir,
        input logic [31:0] tgt, input logic exc, input logic irq_i, input logic [31:0] rdata,
        input logic [31:0] e_pc, input logic e_valid, input logic [31:0] e_instr,
        input logic [31:0] e_pp4, input logic e_we, input logic [31:0] e_epc,
        input logic e_cause);
        vec_t v;
        v.rst = rst; v.stall = stall; v.flush = flush; v.redir = redir; v.tgt = tgt;
        v.exc = exc; v.irq = irq_i; v.rdata = rdata; v.e_pc = e_pc; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_pp4 = e_pp4; v.e_we = e_we; v.e_epc = e_epc;
        v.e_cause = e_cause;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got %08h expected %08h", name, idx, act, exp);
        end
    endtask

    // Drive at the falling edge, let one rising edge pass, then sample.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        reset           = v.rst;
        id_ex_clear     = v.stall;
        if_id_clear     = v.flush;
        redirect        = v.redir;
        redirect_target = v.tgt;
        exception       = v.exc;
        irq             = v.irq;
        imem_rdata      = v.rdata;
        @(posedge clk);
        #1;
        chk("pc", idx, imem_addr, v.e_pc);
        chk("valid", idx, {31'd0, if_id_valid}, {31'd0, v.e_valid});
        chk("instr", idx, if_id_instr, v.e_instr);
        if (v.e_valid)
            chk("pc_plus4", idx, if_id_pc_plus4, v.e_pp4);
        chk("epc_we", idx, {31'd0, epc_we}, {31'd0, v.e_we});
        if (v.e_we || v.rst) begin
            chk("epc", idx, epc, v.e_epc);
            chk("cause_irq", idx, {31'd0, cause_irq}, {31'd0, v.e_cause});
        end
    endtask

    vec_t tbl[$];

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1; id_ex_clear = 1'b0; if_id_clear = 1'b0; redirect = 1'b0;
        redirect_target = 32'd0; exception = 1'b0; irq = 1'b0; imem_rdata = 32'd0;

        //            rst st fl rd tgt           ex ir rdata          pc            v  instr          pp4           we epc           c
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h8000_0000, 0, 32'h0,        32'h0,        0, 32'h0,        0));
        // straight-line fetch
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h1111_1111, 32'h8000_0004, 1, 32'h1111_1111, 32'h8000_0004, 0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h2222_2222, 32'h8000_0008, 1, 32'h2222_2222, 32'h8000_0008, 0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h3333_3333, 32'h8000_000C, 1, 32'h3333_3333, 32'h8000_000C, 0, 32'h0,        0));
        // redirect without flush captures the fetch
        tbl.push_back(mk(0, 0, 0, 1, 32'h0000_000C, 0, 0, 32'h4444_4444, 32'h0000_000C, 1, 32'h4444_4444, 32'h8000_0010, 0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h5555_5555, 32'h0000_0010, 1, 32'h5555_5555, 32'h0000_0010, 0, 32'h0,        0));
        // stall two cycles at PC=10
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        0, 0, 32'h6666_6666, 32'h0000_0010, 1, 32'h5555_5555, 32'h0000_0010, 0, 32'h0,        0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        0, 0, 32'h6666_6666, 32'h0000_0010, 1, 32'h5555_5555, 32'h0000_0010, 0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h7777_7777, 32'h0000_0014, 1, 32'h7777_7777, 32'h0000_0014, 0, 32'h0,        0));
        // taken branch with flush
        tbl.push_back(mk(0, 0, 1, 1, 32'h0000_0040, 0, 0, 32'h8888_8888, 32'h0000_0040, 0, 32'h0,        32'h0,        0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h9999_9999, 32'h0000_0044, 1, 32'h9999_9999, 32'h0000_0044, 0, 32'h0,        0));
        // irq in user mode at PC=20
        tbl.push_back(mk(0, 0, 0, 1, 32'h0000_0020, 0, 0, 32'hAAAA_AAAA, 32'h0000_0020, 1, 32'hAAAA_AAAA, 32'h0000_0048, 0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 32'hBBBB_BBBB, 32'h0000_0024, 1, 32'hBBBB_BBBB, 32'h0000_0024, 0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 32'hCCCC_CCCC, 32'h8000_0004, 0, 32'h0,        32'h0,        1, 32'h0000_0024, 1));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 32'hDDDD_DDDD, 32'h8000_0008, 1, 32'hDDDD_DDDD, 32'h8000_0008, 0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0000_0060, 0, 0, 32'h0F0F_0F0F, 32'h0000_0060, 1, 32'h0F0F_0F0F, 32'h8000_000C, 0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h1234_5678, 32'h0000_0064, 1, 32'h1234_5678, 32'h0000_0064, 0, 32'h0,        0));
        // irq in kernel mode held until jr back to user code
        tbl.push_back(mk(0, 0, 1, 1, 32'h8000_0010, 0, 0, 32'h0,        32'h8000_0010, 0, 32'h0,        32'h0,        0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 32'h0101_0101, 32'h8000_0014, 1, 32'h0101_0101, 32'h8000_0014, 0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 32'h0202_0202, 32'h8000_0018, 1, 32'h0202_0202, 32'h8000_0018, 0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 1, 1, 32'h0000_0030, 0, 1, 32'h0,        32'h0000_0030, 0, 32'h0,        32'h0,        0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0303_0303, 32'h8000_0004, 0, 32'h0,        32'h0,        1, 32'h0000_0030, 1));
        // new edge in kernel, deferred by redirect in user, then exception wins
        tbl.push_back(mk(0, 0, 1, 1, 32'h0000_0008, 0, 1, 32'h0,        32'h0000_0008, 0, 32'h0,        32'h0,        0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0000_000C, 0, 1, 32'h0404_0404, 32'h0000_000C, 1, 32'h0404_0404, 32'h0000_000C, 0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        1, 1, 32'h0,        32'h8000_0008, 0, 32'h0,        32'h0,        1, 32'h0000_0008, 0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 32'h0505_0505, 32'h8000_000C, 1, 32'h0505_0505, 32'h8000_000C, 0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 1, 1, 32'h0000_0100, 0, 1, 32'h0,        32'h0000_0100, 0, 32'h0,        32'h0,        0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h8000_0004, 0, 32'h0,        32'h0,        1, 32'h0000_0100, 1));
        // reset while pending and stalled
        tbl.push_back(mk(0, 0, 1, 1, 32'h0000_0200, 0, 0, 32'h0,        32'h0000_0200, 0, 32'h0,        32'h0,        0, 32'h0,        0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        0, 1, 32'h0,        32'h0000_0200, 0, 32'h0,        32'h0,        0, 32'h0,        0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,        0, 1, 32'h0,        32'h0000_0200, 0, 32'h0,        32'h0,        0, 32'h0,        0));
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,        0, 1, 32'h0,        32'h8000_0000, 0, 32'h0,        32'h0,        0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 1, 1, 32'h0000_0300, 0, 0, 32'h0,        32'h0000_0300, 0, 32'h0,        32'h0,        0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0606_0606, 32'h0000_0304, 1, 32'h0606_0606, 32'h0000_0304, 0, 32'h0,        0));

        foreach (tbl[i]) apply(tbl[i], i);

        // Second edge while pending is absorbed: exactly one accept.
        apply(mk(0, 1, 0, 0, 32'h0, 0, 1, 32'h0, 32'h0000_0304, 1, 32'h0606_0606, 32'h0000_0304, 0, 32'h0, 0), 100);
        apply(mk(0, 1, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0000_0304, 1, 32'h0606_0606, 32'h0000_0304, 0, 32'h0, 0), 101);
        apply(mk(0, 1, 0, 0, 32'h0, 0, 1, 32'h0, 32'h0000_0304, 1, 32'h0606_0606, 32'h0000_0304, 0, 32'h0, 0), 102);
        apply(mk(0, 0, 0, 0, 32'h0, 0, 1, 32'h0, 32'h8000_0004, 0, 32'h0, 32'h0, 1, 32'h0000_0304, 1), 103);
        apply(mk(0, 0, 1, 1, 32'h0000_0500, 0, 1, 32'h0, 32'h0000_0500, 0, 32'h0, 32'h0, 0, 32'h0, 0), 104);
        apply(mk(0, 0, 0, 0, 32'h0, 0, 1, 32'h0707_0707, 32'h0000_0504, 1, 32'h0707_0707, 32'h0000_0504, 0, 32'h0, 0), 105);

        // PC+4 wraps the low 31 bits and keeps bit 31.
        apply(mk(0, 0, 1, 1, 32'h7FFF_FFFC, 0, 0, 32'h0, 32'h7FFF_FFFC, 0, 32'h0, 32'h0, 0, 32'h0, 0), 110);
        apply(mk(0, 0, 0, 0, 32'h0, 0, 0, 32'h0808_0808, 32'h0000_0000, 1, 32'h0808_0808, 32'h0000_0000, 0, 32'h0, 0), 111);
        apply(mk(0, 0, 1, 1, 32'hFFFF_FFFC, 0, 0, 32'h0, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 0, 32'h0, 0), 112);
        apply(mk(0, 0, 0, 0, 32'h0, 0, 0, 32'h0909_0909, 32'h8000_0000, 1, 32'h0909_0909, 32'h8000_0000, 0, 32'h0, 0), 113);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
